// File: rtl/elevator_ctrl_nflr.sv
// N-floor elevator car controller: latches calls, serves them in collecting-scan order, owns door/travel timers.
// Optional fire recall input is enabled by defining ELEV_FIRE_RECALL_EN.
module elevator_ctrl_nflr #(
   parameter int NUM_FLR  = 4,
   parameter int FLR_W    = 2,
   parameter int DOOR_CYC = 8,
   parameter int MOVE_CYC = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_FLR-1:0] car_req,
   input  logic [NUM_FLR-1:0] hall_up,
   input  logic [NUM_FLR-1:0] hall_dn,
   input  logic               door_obst,
`ifdef ELEV_FIRE_RECALL_EN
   input  logic               fire_recall,
`endif
   output logic [FLR_W-1:0]   cur_flr,
   output logic               dir_up,
   output logic               moving,
   output logic               door_open,
   output logic [NUM_FLR-1:0] pend
);

   localparam int DT_W = $clog2(DOOR_CYC);
   localparam int MT_W = (MOVE_CYC > 1) ? $clog2(MOVE_CYC) : 1;

   typedef enum logic [1:0] {IDLE, OPEN, MOVE} state_t;

   state_t             state, state_nxt;
   logic [FLR_W-1:0]   flr_nxt, step_flr;
   logic               dir_nxt;
   logic [DT_W-1:0]    dtmr, dtmr_nxt;
   logic [MT_W-1:0]    mtmr, mtmr_nxt;
   logic [NUM_FLR-1:0] req_all, clr, pend_nxt, cur_oh, step_oh;
   logic               cur_hit, step_hit, above, below, step_fwd, fire;

`ifdef ELEV_FIRE_RECALL_EN
   assign fire = fire_recall;
`else
   assign fire = 1'b0;
`endif

   assign req_all   = car_req | hall_up | hall_dn;
   assign door_open = (state == OPEN);
   assign moving    = (state == MOVE);

   // Call geometry relative to the current floor and to the floor reached at the end of this step.
   always_comb begin
      step_flr = dir_up ? cur_flr + FLR_W'(1) : cur_flr - FLR_W'(1);
      cur_oh   = '0;
      step_oh  = '0;
      above    = 1'b0;
      below    = 1'b0;
      step_fwd = 1'b0;
      for (int k = 0; k < NUM_FLR; k++) begin
         cur_oh[k]  = (k == int'(cur_flr));
         step_oh[k] = (k == int'(step_flr));
         if (k > int'(cur_flr)) above = above | pend[k];
         if (k < int'(cur_flr)) below = below | pend[k];
         if (dir_up ? (k > int'(step_flr)) : (k < int'(step_flr))) step_fwd = step_fwd | pend[k];
      end
      cur_hit  = |(pend & cur_oh);
      step_hit = |(pend & step_oh);
   end

   always_comb begin
      state_nxt = state;
      flr_nxt   = cur_flr;
      dir_nxt   = dir_up;
      dtmr_nxt  = dtmr;
      mtmr_nxt  = mtmr;
      clr       = '0;
      case (state)
         IDLE: begin
            if (fire) begin
               if (cur_flr == '0) begin
                  state_nxt = OPEN;
                  dtmr_nxt  = DT_W'(DOOR_CYC - 1);
               end else begin
                  state_nxt = MOVE;
                  dir_nxt   = 1'b0;
                  mtmr_nxt  = MT_W'(MOVE_CYC - 1);
               end
            end else if (cur_hit) begin
               state_nxt = OPEN;
               dtmr_nxt  = DT_W'(DOOR_CYC - 1);
               clr       = cur_oh;
            end else if (dir_up ? above : below) begin
               state_nxt = MOVE;
               mtmr_nxt  = MT_W'(MOVE_CYC - 1);
            end else if (dir_up ? below : above) begin
               state_nxt = MOVE;
               dir_nxt   = ~dir_up;
               mtmr_nxt  = MT_W'(MOVE_CYC - 1);
            end
         end
         OPEN: begin
            // Same-floor presses are swallowed while the door is open; they only extend the dwell.
            clr = cur_oh;
            if (fire && cur_flr != '0)
               state_nxt = IDLE;
            else if (fire || door_obst || |(req_all & cur_oh))
               dtmr_nxt = DT_W'(DOOR_CYC - 1);
            else if (dtmr == '0)
               state_nxt = IDLE;
            else
               dtmr_nxt = dtmr - DT_W'(1);
         end
         MOVE: begin
            if (mtmr == '0) begin
               flr_nxt = step_flr;
               if (fire) begin
                  if (step_flr == '0) begin
                     state_nxt = OPEN;
                     dtmr_nxt  = DT_W'(DOOR_CYC - 1);
                  end else begin
                     dir_nxt  = 1'b0;
                     mtmr_nxt = MT_W'(MOVE_CYC - 1);
                  end
               end else if (step_hit) begin
                  state_nxt = OPEN;
                  dtmr_nxt  = DT_W'(DOOR_CYC - 1);
                  clr       = step_oh;
               end else if (step_fwd) begin
                  mtmr_nxt = MT_W'(MOVE_CYC - 1);
               end else begin
                  state_nxt = IDLE;
               end
            end else begin
               mtmr_nxt = mtmr - MT_W'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase
      pend_nxt = fire ? '0 : ((pend | req_all) & ~clr);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         cur_flr <= '0;
         dir_up  <= 1'b1;
         pend    <= '0;
         dtmr    <= '0;
         mtmr    <= '0;
      end else begin
         state   <= state_nxt;
         cur_flr <= flr_nxt;
         dir_up  <= dir_nxt;
         pend    <= pend_nxt;
         dtmr    <= dtmr_nxt;
         mtmr    <= mtmr_nxt;
      end
   end

endmodule

// File: tb/tb_elevator_ctrl_nflr.sv
// Scoreboard bench for elevator_ctrl_nflr: a trip-level scan model predicts door-open events.
module tb_elevator_ctrl_nflr;
   localparam int NF = 4;
   localparam int FW = 2;
   localparam int DC = 8;
   localparam int MC = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [NF-1:0] car_req = '0, hall_up = '0, hall_dn = '0;
   logic          door_obst = 1'b0;
   logic [FW-1:0] cur_flr;
   logic          dir_up, moving, door_open;
   logic [NF-1:0] pend;

   elevator_ctrl_nflr #(.NUM_FLR(NF), .FLR_W(FW), .DOOR_CYC(DC), .MOVE_CYC(MC)) dut (
      .clk(clk), .reset(reset), .car_req(car_req), .hall_up(hall_up), .hall_dn(hall_dn),
      .door_obst(door_obst),
`ifdef ELEV_FIRE_RECALL_EN
      .fire_recall(1'b0),
`endif
      .cur_flr(cur_flr), .dir_up(dir_up), .moving(moving), .door_open(door_open), .pend(pend));

   always #5 clk = ~clk;

   typedef struct {int flr; int gap; int dwell;} exp_t;
   exp_t sb[$];
   int   n_chk = 0, n_pass = 0;
   int   cyc = 0, t_ref = 0;
   int   m_flr = 0;
   bit   m_dir = 1'b1;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int req);
      n_chk++;
      if (act == req) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
   endtask

   // Monitor: every door opening must match the next predicted stop, its travel gap and its dwell.
   initial begin : mon
      bit prev_open;
      int t_open, dwell;
      exp_t e;
      prev_open = 1'b0; t_open = 0; dwell = DC;
      forever begin
         @(negedge clk);
         if (reset) prev_open = 1'b0;
         else begin
            if (door_open && !prev_open) begin
               chk("moving_at_open", int'(moving), 0);
               chk("open_expected", int'(sb.size() > 0), 1);
               if (sb.size() > 0) begin
                  e = sb.pop_front();
                  chk("open_floor", int'(cur_flr), e.flr);
                  chk("open_gap", cyc - t_ref, e.gap);
                  dwell  = e.dwell;
                  t_open = cyc;
               end
            end else if (!door_open && prev_open) begin
               chk("dwell", cyc - t_open, dwell);
               chk("moving_at_close", int'(moving), 0);
               t_ref = cyc;
            end
            prev_open = door_open;
         end
      end
   end

   // Scan model: current floor first, then calls ahead in order, then calls behind in reverse order.
   task automatic plan(input logic [NF-1:0] mask);
      int stops[$];
      int f, last;
      bit behind;
      f = m_flr; behind = 1'b0;
      if (mask[f]) stops.push_back(f);
      if (m_dir) begin
         for (int k = f + 1; k < NF; k++) if (mask[k]) stops.push_back(k);
         for (int k = f - 1; k >= 0; k--) if (mask[k]) begin stops.push_back(k); behind = 1'b1; end
      end else begin
         for (int k = f - 1; k >= 0; k--) if (mask[k]) stops.push_back(k);
         for (int k = f + 1; k < NF; k++) if (mask[k]) begin stops.push_back(k); behind = 1'b1; end
      end
      last = f;
      foreach (stops[i]) begin
         sb.push_back('{stops[i], 1 + MC * ((stops[i] > last) ? stops[i] - last : last - stops[i]), DC});
         last = stops[i];
      end
      m_flr = last;
      if (behind) m_dir = !m_dir;
   endtask

   task automatic pulse(input logic [NF-1:0] mask);
      for (int k = 0; k < NF; k++) if (mask[k]) begin
         case ($urandom_range(0, 2))
            0: car_req[k] = 1'b1;
            1: hall_up[k] = 1'b1;
            default: hall_dn[k] = 1'b1;
         endcase
      end
      @(posedge clk); #1;
      t_ref = cyc;
      car_req = '0; hall_up = '0; hall_dn = '0;
   endtask

   task automatic settle();
      int n;
      n = 0;
      while (!(sb.size() == 0 && !door_open && !moving) && n < 600) begin
         @(negedge clk); n++;
      end
      chk("settle_in_time", int'(n < 600), 1);
      if (n >= 600) sb.delete();
      @(negedge clk);
      chk("idle_pend", int'(pend), 0);
      chk("idle_floor", int'(cur_flr), m_flr);
      chk("idle_dir", int'(dir_up), int'(m_dir));
   endtask

   task automatic batch(input logic [NF-1:0] mask);
      plan(mask);
      pulse(mask);
      settle();
   endtask

   // Obstruction and a held same-floor button for n edges; door stays open n-2 edges plus a full dwell.
   task automatic obst_test(input int n);
      int f;
      f = m_flr;
      sb.push_back('{f, 1, n + 6});
      car_req[f] = 1'b1;
      door_obst  = 1'b1;
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         if (i == 0) t_ref = cyc;
      end
      car_req = '0; door_obst = 1'b0;
      settle();
   endtask

   initial begin : stim
      int n;
      logic [NF-1:0] m;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_floor", int'(cur_flr), 0);
      chk("rst_dir", int'(dir_up), 1);
      chk("rst_moving", int'(moving), 0);
      chk("rst_door", int'(door_open), 0);
      chk("rst_pend", int'(pend), 0);
      reset = 1'b0;
      @(negedge clk);

      // Call at the current floor: pend visible next cycle, then a plain dwell.
      plan(4'b0001);
      car_req = 4'b0001;
      @(posedge clk); #1;
      t_ref = cyc;
      car_req = '0;
      chk("pend_latched", int'(pend), 1);
      settle();

      batch(4'b1000);
      batch(4'b0001);

      // Calls for floors 1 and 2 arrive after departure but before floor 1 is reached.
      plan(4'b1110);
      car_req = 4'b1000;
      @(posedge clk); #1;
      t_ref = cyc;
      car_req = '0;
      @(posedge clk); #1;
      hall_dn[2] = 1'b1; car_req[1] = 1'b1;
      @(posedge clk); #1;
      hall_dn = '0; car_req = '0;
      settle();

      batch(4'b0001);
      batch(4'b0100);
      batch(4'b1001);
      batch(4'b0100);
      obst_test(20);

      repeat (30) begin
         m = NF'($urandom_range(1, (1 << NF) - 1));
         batch(m);
      end

      // Reset in the middle of a trip between floors 1 and 2.
      batch(4'b0001);
      car_req = 4'b1000;
      @(posedge clk); #1;
      car_req = '0;
      n = 0;
      while (cur_flr != FW'(1) && n < 100) begin @(negedge clk); n++; end
      chk("reach_floor1", int'(n < 100), 1);
      @(posedge clk); #1;
      chk("moving_before_rst", int'(moving), 1);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      sb.delete();
      m_flr = 0; m_dir = 1'b1;
      chk("midrst_floor", int'(cur_flr), 0);
      chk("midrst_moving", int'(moving), 0);
      chk("midrst_door", int'(door_open), 0);
      chk("midrst_pend", int'(pend), 0);
      chk("midrst_dir", int'(dir_up), 1);
      @(negedge clk);
      batch(4'b0100);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/elevator_ctrl_nflr.md
Name: elevator_ctrl_nflr

Overview:
Parametrised N-floor elevator car controller. Latches car and hall call buttons into a pending-request vector and serves them in collecting-scan order: continue in the current direction while calls remain ahead, then reverse. Owns the door-dwell timer and the per-floor travel timer. Sits between the button/sensor front end and the motor/door drivers.

Parameters:
NUM_FLR, 4, number of floors (2..16); floors indexed 0..NUM_FLR-1.
FLR_W, 2, width of floor index; must satisfy 2**FLR_W >= NUM_FLR.
DOOR_CYC, 8, cycles door_open stays high with no re-trigger (>=2).
MOVE_CYC, 4, cycles of travel per floor (>=1).

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
car_req  in  NUM_FLR  in-car floor buttons, bit k = floor k, level or pulse
hall_up  in  NUM_FLR  hall up-call buttons
hall_dn  in  NUM_FLR  hall down-call buttons
door_obst  in  1  door obstruction sensor
cur_flr  out  FLR_W  current or last-passed floor
dir_up  out  1  travel direction, 1 = up
moving  out  1  motor run command
door_open  out  1  door open command
pend  out  NUM_FLR  latched pending requests

Behaviour:
- Clock clk; reset is synchronous, active-high. Reset values: state IDLE, cur_flr=0, dir_up=1, moving=0, door_open=0, pend=0. Reset overrides everything, including mid-travel and mid-dwell.
- Request latch: at each edge, pend[k] <= pend[k] | car_req[k] | hall_up[k] | hall_dn[k], except for the clears below. A request is visible on pend one cycle after it is sampled.
- FSM decisions use registered pend only. above = any pend bit above cur_flr; below = any pend bit below cur_flr.
- IDLE (door_open=0, moving=0), in priority order:
  - pend[cur_flr] set: go to OPEN.
  - Otherwise, a call lies in direction dir_up: go to MOVE, keep dir_up.
  - Otherwise, a call lies in the opposite direction: flip dir_up, go to MOVE.
  - Otherwise: stay in IDLE.
- OPEN: door_open=1; dwell timer loaded with DOOR_CYC-1 on entry; pend[cur_flr] cleared on entry.
  - While in OPEN, any request for cur_flr is not latched and reloads the timer. door_obst=1 also reloads the timer.
  - Timer reaches 0 with no reload: go to IDLE; door_open falls on that edge.
  - Unobstructed dwell is exactly DOOR_CYC cycles.
- MOVE: moving=1; travel counter runs MOVE_CYC cycles.
  - On the final cycle edge, cur_flr increments when dir_up=1 and decrements when dir_up=0.
  - After that edge, evaluated on the new floor:
    - pend[new floor] set: go to OPEN.
    - Otherwise, a call remains further in dir_up: stay in MOVE and restart the counter.
    - Otherwise: go to IDLE.
- Bounds: cur_flr never leaves 0..NUM_FLR-1. MOVE is never entered toward a wall, because no call can exist beyond it.
- Calls arriving during MOVE for floors already passed are latched and served after reversal.
- moving and door_open are never high together.

Optional Feature:
ELEV_FIRE_RECALL_EN
- Defined: adds input fire_recall (1 bit).
- While fire_recall=1: pend is held at 0, all buttons are ignored and door_obst is ignored.
  - Car in OPEN: door closes next cycle.
  - Car not at floor 0: travels down to floor 0 without stopping.
  - At floor 0: door_open=1 is held until fire_recall=0; normal dwell then follows.
- Undefined: port absent, normal behaviour only.

Test Plan:
All scenarios use NUM_FLR=4, DOOR_CYC=8, MOVE_CYC=4.
1. Reset, 1-cycle pulse car_req=4'b0001 -> pend[0] set next cycle; door_open high exactly 8 cycles; cur_flr=0; moving stays 0.
2. Idle at floor 0, pulse car_req[3] -> moving=1, dir_up=1; cur_flr steps 1,2,3 at 4-cycle spacing; then door_open=1 with moving=0; pend=0.
3. Car moving up from floor 0 toward a call at 3; hall_dn[2] and car_req[1] pulsed before cur_flr=1 -> stops and opens at 1, then 2, then 3; each dwell 8 cycles.
4. Door open at floor 2, door_obst held high 20 cycles -> door_open stays high throughout and for 8 cycles after release; pend[2] never re-set.
5. After an upward trip ends at floor 2 with dir_up=1, pend = floors 0 and 3 -> serves 3 first, then reverses to 0 with dir_up=0.
6. reset asserted while moving=1 between floors 1 and 2 -> next cycle cur_flr=0, moving=0, door_open=0, pend=0, dir_up=1.
